param_reg_file: RTL
===================

PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per register (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of registers (power of two, 2..256); AW = log2(DEPTH) SHALL be a derived localparam.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port RegFileRead, input, 1, read request for both read ports.
REQ-006 The block SHALL have port RegFileWrite, input, 1, write request.
REQ-007 The block SHALL have port Datain, input, WIDTH, write data.
REQ-008 The block SHALL have ports Source1 and Source2, input, AW each, read addresses.
REQ-009 The block SHALL have port Destin, input, AW, write address.
REQ-010 The block SHALL have port Clear, input, 1, request to zero all registers sequentially.
REQ-011 The block SHALL have ports Dataout1 and Dataout2, output, WIDTH each, registered read data.
REQ-012 The block SHALL have port ReadValid, output, 1, high for exactly the cycle after an accepted read.
REQ-013 The block SHALL have port Busy, output, 1, high while a clear sequence is in progress.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and CLEARING.
REQ-015 In IDLE with RegFileWrite=1 and Clear=0, the block SHALL set reg[Destin] to Datain at the rising edge.
REQ-016 In IDLE with RegFileRead=1, the block SHALL load Dataout1 from reg[Source1] and Dataout2 from reg[Source2] at the edge, and set ReadValid=1 (1-cycle latency).
REQ-017 When no read is accepted, Dataout1/Dataout2 SHALL hold their last values and ReadValid SHALL be 0.
REQ-018 Source1 equal to Source2 SHALL return identical data on both ports.
REQ-019 In IDLE with Clear=1 at an edge, the FSM SHALL go to CLEARING with clear counter=0 and Busy=1; Clear SHALL take priority, and a simultaneous write or read SHALL be dropped.
REQ-020 In CLEARING, each edge SHALL set reg[counter] to 0 and increment the counter; on the edge that clears index DEPTH-1, the FSM SHALL return to IDLE with Busy=0 (Busy high exactly DEPTH cycles).
REQ-021 In CLEARING, RegFileWrite, RegFileRead and Clear SHALL be ignored, and ReadValid SHALL stay 0 with Dataout held.
REQ-022 Addresses SHALL cover the full AW range; no out-of-range case exists.

Reset
REQ-023 When Reset_n=0, the block SHALL immediately force all registers, Dataout1, Dataout2, ReadValid, Busy and the counter to 0, and the FSM to IDLE, regardless of clk.
REQ-024 Reset asserted mid-clear SHALL abort the sequence; after release, the FSM SHALL be in IDLE with all registers zero.
REQ-025 The first edge after release SHALL accept a read, write or clear normally.

Configuration
REQ-026 When macro REGFILE_BYPASS_EN is defined, an accepted read whose Source equals Destin of a same-cycle accepted write SHALL return Datain on that port.
REQ-027 When REGFILE_BYPASS_EN is undefined, that same case SHALL return the pre-write register value; the write SHALL still complete.

Verification
REQ-028 Scenario: reset, write 0xA5 to r3, then read Source1=3, Source2=0 -> next cycle Dataout1=0xA5, Dataout2=0x00, ReadValid=1.
REQ-029 Scenario: same cycle write Destin=5, Datain=0x3C and read Source1=5 with r5=0x11 -> Dataout1=0x3C with REGFILE_BYPASS_EN, 0x11 without; r5=0x3C afterwards in both builds.
REQ-030 Scenario: fill all 16 registers with nonzero data, pulse Clear -> Busy high exactly 16 cycles, writes during Busy are ignored, and reads of all registers return 0 afterwards.
REQ-031 Scenario: Clear and RegFileWrite (r2, 0xFF) in the same IDLE cycle -> clear starts and r2=0 after clear completes.
REQ-032 Scenario: assert Reset_n low at clear cycle 7 -> outputs 0 asynchronously; after release Busy=0, FSM IDLE, and a read returns 0 from all registers.
REQ-033 Scenario: WIDTH=32, DEPTH=32 build, write 0xDEADBEEF to r31 -> a read of r31 returns 0xDEADBEEF with ReadValid=1.

Source files
------------

// File: rtl/param_reg_file.sv
// param_reg_file: parameterised two-read/one-write register file with sequential clear
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module param_reg_file #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             RegFileRead,
    input  logic             RegFileWrite,
    input  logic [WIDTH-1:0] Datain,
    input  logic [AW-1:0]    Source1,
    input  logic [AW-1:0]    Source2,
    input  logic [AW-1:0]    Destin,
    input  logic             Clear,
    output logic [WIDTH-1:0] Dataout1,
    output logic [WIDTH-1:0] Dataout2,
    output logic             ReadValid,
    output logic             Busy
);
    typedef enum logic {IDLE, CLEARING} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout1;
    logic [WIDTH-1:0] r_dout2;
    logic             r_valid;
    logic             r_busy;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

`ifdef REGFILE_BYPASS_EN
    // A read only happens when Clear is low, so a requested write is always accepted alongside it
    assign w_rd1 = (RegFileWrite && Destin == Source1) ? Datain : r_mem[Source1];
    assign w_rd2 = (RegFileWrite && Destin == Source2) ? Datain : r_mem[Source2];
`else
    assign w_rd1 = r_mem[Source1];
    assign w_rd2 = r_mem[Source2];
`endif

    assign Dataout1  = r_dout1;
    assign Dataout2  = r_dout2;
    assign ReadValid = r_valid;
    assign Busy      = r_busy;

    // FSM, storage and registered outputs; Clear wins over read/write in IDLE, all requests ignored while clearing
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dout1 <= '0;
            r_dout2 <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Clear) begin
                        r_state <= CLEARING;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        if (RegFileWrite) r_mem[Destin] <= Datain;
                        if (RegFileRead) begin
                            r_dout1 <= w_rd1;
                            r_dout2 <= w_rd2;
                            r_valid <= 1'b1;
                        end
                    end
                end
                CLEARING: begin
                    r_mem[r_cnt] <= '0;
                    r_cnt        <= r_cnt + AW'(1);
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
